// File: rtl/ws_pkg.sv
// Shared definitions for the weight-stationary array sequencer: FSM states,
// default array dimensions and the default result latency.
package ws_pkg;

    localparam int unsigned WS_ROWS  = 4;
    localparam int unsigned WS_COLS  = 4;
    localparam int unsigned WS_VEC_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StDone
    } ws_state_e;

    // Activation read to result at the array bottom, including skew/deskew.
    function automatic int unsigned ws_default_lat(input int unsigned rows,
                                                   input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/ws_result_tracker.sv
// LAT-stage delay line of {valid, idx}: the entry pushed with an activation
// read pops out exactly LAT cycles later as the matching result vector.
module ws_result_tracker #(
    parameter int unsigned LAT   = 7,
    parameter int unsigned VEC_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [VEC_W-1:0] i_idx,
    output logic             o_valid,
    output logic [VEC_W-1:0] o_idx
);

    logic [LAT-1:0]            r_valid;
    logic [LAT-1:0][VEC_W-1:0] r_idx;

    // Shift the tracking entries one stage per cycle; flush drops everything in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_idx   <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_idx   <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int unsigned s = 1; s < LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_idx[s]   <= r_idx[s-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_idx   = r_idx[LAT-1];

endmodule

// File: rtl/ws_array_ctrl.sv
// Job sequencer for a weight-stationary systolic array: loads weights bottom
// row first, streams activation vectors, then drains while flagging results.
// Every output is a flop driven from the next-state decode.
module ws_array_ctrl
    import ws_pkg::*;
#(
    parameter int unsigned ROWS  = WS_ROWS,
    parameter int unsigned COLS  = WS_COLS,
    parameter int unsigned VEC_W = WS_VEC_W,
    parameter int unsigned LAT   = ws_default_lat(ROWS, COLS),
    localparam int unsigned AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [VEC_W-1:0] i_num_vec,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_weight_we,
    output logic             o_w_rd_en,
    output logic [AW-1:0]    o_w_rd_addr,
    output logic             o_act_rd_en,
    output logic [VEC_W-1:0] o_act_rd_addr,
    output logic             o_res_valid,
    output logic [VEC_W-1:0] o_res_idx
);

    localparam logic [VEC_W-1:0] LOAD_LAST = VEC_W'(ROWS - 1);
    localparam logic [AW-1:0]    ADDR_TOP  = AW'(ROWS - 1);

    ws_state_e        r_state, w_state_d;
    logic [VEC_W-1:0] r_cnt, w_cnt_d;
    logic [VEC_W-1:0] r_num, w_num_d;

    logic             r_busy, r_done, r_weight_we, r_w_rd_en, r_act_rd_en;
    logic [AW-1:0]    r_w_rd_addr;
    logic [VEC_W-1:0] r_act_rd_addr;

    logic             w_busy_d, w_done_d, w_load_d, w_act_d;
    logic [AW-1:0]    w_w_rd_addr_d;
    logic [VEC_W-1:0] w_act_rd_addr_d;
    logic [VEC_W-1:0] w_num_last;
    logic             w_res_valid;
    logic [VEC_W-1:0] w_res_idx;

    // Only meaningful when r_num != 0; every use is guarded accordingly.
    assign w_num_last = r_num - VEC_W'(1);

    // Next state and counters; abort overrides everything, including a start in IDLE.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_num_d   = r_num;
        if (i_abort) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_d = StLoad;
                        w_cnt_d   = '0;
                        w_num_d   = i_num_vec;
                    end
                end
                StLoad: begin
                    if (r_cnt == LOAD_LAST) begin
                        w_cnt_d   = '0;
                        w_state_d = (r_num == '0) ? StDrain : StCompute;
                    end else begin
                        w_cnt_d = r_cnt + VEC_W'(1);
                    end
                end
                StCompute: begin
                    if (r_cnt == w_num_last) begin
                        w_cnt_d   = '0;
                        w_state_d = StDrain;
                    end else begin
                        w_cnt_d = r_cnt + VEC_W'(1);
                    end
                end
                StDrain: begin
                    // Leave once the last result vector is on the outputs this cycle.
                    if ((r_num == '0) || (w_res_valid && (w_res_idx == w_num_last))) begin
                        w_state_d = StDone;
                    end
                end
                StDone: begin
                    w_state_d = StIdle;
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Decode the next-cycle output values from the next state so outputs can be registered.
    always_comb begin
        w_busy_d        = (w_state_d != StIdle);
        w_done_d        = (w_state_d == StDone);
        w_load_d        = (w_state_d == StLoad);
        w_act_d         = (w_state_d == StCompute);
        w_w_rd_addr_d   = '0;
        w_act_rd_addr_d = '0;
        if (w_load_d) begin
            // Bottom row first so pass-through registers settle each row on the last load cycle.
            w_w_rd_addr_d = ADDR_TOP - w_cnt_d[AW-1:0];
        end
        if (w_act_d) begin
            w_act_rd_addr_d = w_cnt_d;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_num         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_weight_we   <= 1'b0;
            r_w_rd_en     <= 1'b0;
            r_w_rd_addr   <= '0;
            r_act_rd_en   <= 1'b0;
            r_act_rd_addr <= '0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_num         <= w_num_d;
            r_busy        <= w_busy_d;
            r_done        <= w_done_d;
            r_weight_we   <= w_load_d;
            r_w_rd_en     <= w_load_d;
            r_w_rd_addr   <= w_w_rd_addr_d;
            r_act_rd_en   <= w_act_d;
            r_act_rd_addr <= w_act_rd_addr_d;
        end
    end

    ws_result_tracker #(
        .LAT   (LAT),
        .VEC_W (VEC_W)
    ) u_tracker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_abort),
        .i_valid (r_act_rd_en),
        .i_idx   (r_act_rd_addr),
        .o_valid (w_res_valid),
        .o_idx   (w_res_idx)
    );

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_weight_we   = r_weight_we;
    assign o_w_rd_en     = r_w_rd_en;
    assign o_w_rd_addr   = r_w_rd_addr;
    assign o_act_rd_en   = r_act_rd_en;
    assign o_act_rd_addr = r_act_rd_addr;
    assign o_res_valid   = w_res_valid;
    assign o_res_idx     = w_res_idx;

endmodule

// File: doc/ws_array_ctrl.md
Name: ws_array_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array built from pe_datapath_ws tiles.
- Runs one tile job per start pulse: shifts weights down the columns, streams activation vectors, then waits for the pipeline to drain while flagging result vectors.
- Sits between the job front end (start/done plus counts) and the array, weight buffer and activation buffer.
- Does not touch data; it drives only enables, addresses and valid flags.

Parameters:
- ROWS, 4, array rows; also the weight-load depth.
- COLS, 4, array columns.
- VEC_W, 16, width of the vector-count field.
- LAT, ROWS+COLS-1, cycles from an activation read to its matching result vector at the array bottom, including external skew/deskew.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- num_vec  in  VEC_W  activation vectors in the job; latched on accepted start.
- abort  in  1  synchronous cancel; returns to IDLE.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- weight_we  out  1  broadcast to every PE weight_we.
- w_rd_en  out  1  weight buffer read enable.
- w_rd_addr  out  clog2(ROWS)  weight row address.
- act_rd_en  out  1  activation buffer read enable.
- act_rd_addr  out  VEC_W  activation vector index.
- res_valid  out  1  array bottom carries a completed result vector.
- res_idx  out  VEC_W  index of that result vector.

Behaviour:
- All outputs are registered.
- Buffer reads are combinational: an address and its data appear in the same cycle.
- Reset values: state IDLE; all outputs and counters 0.
- IDLE:
  - busy=0.
  - start=1 latches num_vec, zeroes the counters and moves to LOAD next cycle.
  - start outside IDLE is ignored.
- LOAD, exactly ROWS cycles, k=0..ROWS-1:
  - weight_we=1, w_rd_en=1, w_rd_addr=ROWS-1-k.
  - The bottom row's weights are fed first, so the PE pass-through registers deliver row r its own weights on the last load cycle.
  - Moves to COMPUTE, or to DRAIN if num_vec==0.
- COMPUTE, exactly num_vec cycles, i=0..num_vec-1:
  - weight_we=0, act_rd_en=1, act_rd_addr=i.
  - Moves to DRAIN.
- DRAIN:
  - Holds until the last res_valid has been issued.
  - If num_vec==0, lasts 1 cycle with no res_valid.
- DONE:
  - done=1 for one cycle, busy still 1.
  - Next cycle returns to IDLE. start is accepted again in that IDLE cycle.
- busy: 1 from the first LOAD cycle through the DONE cycle.
- Results:
  - res_valid=1 and res_idx=i exactly LAT cycles after the cycle act_rd_en=1 with act_rd_addr=i.
  - Implemented with a LAT-deep shift register of {valid, idx}, or a down-counter plus issue counter.
  - res_valid may overlap COMPUTE when num_vec > LAT.
- Width rules:
  - Counters are VEC_W bits and compare against the latched num_vec.
  - num_vec = 2^VEC_W-1 is legal, so there is no wrap before the compare.
- abort:
  - Takes effect from any non-IDLE state. Next cycle: state IDLE, every enable and valid 0, result pipeline flushed, no done pulse.
  - abort and start together in IDLE: abort wins and the start is dropped.
- Async rst mid-job: all state clears immediately. Array contents are undefined; the next job reloads the weights.
- Weights in the array are stale after a job; every job reloads them.

Decomposition:
- Shared package ws_pkg:
  - FSM state enum (IDLE, LOAD, COMPUTE, DRAIN, DONE).
  - Array dimension constants.
  - Default LAT function.
- One natural sub-module: ws_result_tracker, the LAT-stage {valid, idx} delay line with flush.

Test Plan (ROWS=COLS=4, LAT=7, start accepted at cycle 0):
- num_vec=3:
  - LOAD at cycles 1-4 with w_rd_addr 3,2,1,0 and weight_we=1.
  - act_rd_addr 0,1,2 at cycles 5-7.
  - res_valid at cycles 12,13,14 with idx 0,1,2.
  - done at cycle 15, busy 1 over cycles 1-15.
- num_vec=0: LOAD at cycles 1-4, DRAIN at cycle 5, done at cycle 6; act_rd_en and res_valid never asserted.
- num_vec=10:
  - act at cycles 5-14, res_valid at cycles 12-21 (overlapping COMPUTE at cycles 12-14).
  - done at cycle 22.
- abort at cycle 6 with num_vec=3: from cycle 7 all outputs are 0 and state is IDLE; no res_valid and no done ever appear.
- start held high across a job, then a second job: the second job's LOAD begins the cycle after the first job's IDLE re-entry. A start presented during busy is never queued.
- Async rst asserted mid-COMPUTE (between clock edges): all outputs drop to 0 immediately. After release, a new start runs a clean job matching the first scenario.
